// File: rtl/io_input_mmio.sv
// Memory-mapped switch/button input block: 2-flop sync, tick-sampled debounce, sticky W1C press flags, maskable irq.
// Loads return registered data one cycle after the request; there is no backpressure (core load stall absorbs latency).
module io_input_mmio #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_7800,
    parameter int          TICK_CYCLES    = 50000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    input  logic [31:0] i_lsu_addr,
    input  logic        i_lsu_rden,
    input  logic        i_lsu_wren,
    input  logic [31:0] i_st_data,
    output logic        o_hit,
    output logic [31:0] o_ld_data,
    output logic        o_ld_vld,
    output logic        o_irq
);

    localparam int          CW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [3:0]  BTN_INV = BTN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [35:0]   sync1, sync2, in_sync;
    logic [35:0]   smp0, smp1;
    logic [35:0]   deb, deb_next;
    logic [3:0]    btn_edge, btn_edge_next, edge_set, edge_clr;
    logic [3:0]    mask, mask_next;
    logic          wr_hit, rd_hit;
    logic [1:0]    off;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign unused_bits = &{1'b0, i_lsu_addr[1:0], i_st_data[31:4]};

    assign o_hit  = (i_lsu_addr[31:4] == BASE_ADDR[31:4]);
    assign off    = i_lsu_addr[3:2];
    assign wr_hit = i_lsu_wren & o_hit;
    assign rd_hit = i_lsu_rden & o_hit;

    assign tick    = (cnt == CW'(TICK_CYCLES - 1));
    assign in_sync = {sync2[35:32] ^ BTN_INV, sync2[31:0]};

    // Window is the new sample plus the two stored ones: all-1 -> 1, all-0 -> 0, mixed -> hold.
    always_comb begin
        deb_next = deb;
        if (tick) begin
            deb_next = (in_sync & smp0 & smp1) | (deb & (in_sync | smp0 | smp1));
        end
    end

    assign edge_set      = deb_next[35:32] & ~deb[35:32];
    assign edge_clr      = (wr_hit && off == 2'd2) ? i_st_data[3:0] : 4'h0;
    assign btn_edge_next = (btn_edge & ~edge_clr) | edge_set;
    assign mask_next     = (wr_hit && off == 2'd3) ? i_st_data[3:0] : mask;

    always_comb begin
        rd_mux = 32'h0;
        case (off)
            2'd0:    rd_mux = deb[31:0];
            2'd1:    rd_mux = {28'h0, deb[35:32]};
            2'd2:    rd_mux = {28'h0, btn_edge};
            default: rd_mux = {28'h0, mask};
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt   <= '0;
            sync1 <= '0;
            sync2 <= '0;
            smp0  <= '0;
            smp1  <= '0;
            deb   <= '0;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            sync1 <= {i_io_btn, i_io_sw};
            sync2 <= sync1;
            if (tick) begin
                smp0 <= in_sync;
                smp1 <= smp0;
            end
            deb <= deb_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_edge  <= '0;
            mask      <= '0;
            o_irq     <= 1'b0;
            o_ld_vld  <= 1'b0;
            o_ld_data <= '0;
        end else begin
            btn_edge  <= btn_edge_next;
            mask      <= mask_next;
            o_irq     <= |(btn_edge_next & mask_next);
            o_ld_vld  <= rd_hit;
            o_ld_data <= rd_hit ? rd_mux : 32'h0;
        end
    end

endmodule
